// File: rtl/instruction_cache_pkg.sv
// Shared encodings for the instruction cache: main-memory commands and status,
// refill FSM states and the memory-order to instruction-order byte swap.
package instruction_cache_pkg;

  typedef enum logic [1:0] {
    MEM_NOP   = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } mem_cmd_e;

  typedef enum logic [1:0] {
    MEM_RESTING       = 2'b00,
    MEM_DATA_FINISHED = 2'b01,
    MEM_INST_FINISHED = 2'b10
  } mem_status_e;

  typedef enum logic [1:0] {
    ICACHE_IDLE      = 2'b00,
    ICACHE_FILL_REQ  = 2'b01,
    ICACHE_FILL_WAIT = 2'b10
  } icache_state_e;

  // Memory delivers addr+0 in the top byte; instructions are little-endian.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// I-cache port to main memory: refill command/address out, status/data back.
interface instruction_cache_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
);
  logic [1:0]            mem_status;
  logic [LEN-1:0]        mem_data;
  logic [1:0]            i_cache_mem_vis_signal;
  logic [ADDR_WIDTH-1:0] i_cache_mem_vis_addr;

  modport master (
    input  mem_status, mem_data,
    output i_cache_mem_vis_signal, i_cache_mem_vis_addr
  );

  modport slave (
    output mem_status, mem_data,
    input  i_cache_mem_vis_signal, i_cache_mem_vis_addr
  );
endinterface

// File: rtl/icache_data_array.sv
// Tag, valid and word-addressed data storage for the direct-mapped i-cache.
// Writes are synchronous, reads are combinational.
module icache_data_array #(
  parameter int LEN        = 32,
  parameter int INDEX_SIZE = 6,
  parameter int WSEL_W     = 2,
  parameter int TAG_W      = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_SIZE-1:0] rd_index,
  input  logic [WSEL_W-1:0]     rd_word,
  output logic [LEN-1:0]        rd_data,
  output logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [INDEX_SIZE-1:0] wr_index,
  input  logic [WSEL_W-1:0]     wr_word,
  input  logic [LEN-1:0]        wr_data,
  input  logic                  set_valid,
  input  logic [TAG_W-1:0]      set_tag,
  input  logic                  flush
);
  localparam int LINES = 1 << INDEX_SIZE;
  localparam int WORDS = LINES << WSEL_W;

  logic [LEN-1:0]   data_ram [0:WORDS-1];
  logic [TAG_W-1:0] tag_ram  [0:LINES-1];
  logic [LINES-1:0] valid_q;

  // NOTE: data and tag RAMs are not reset; the valid bits alone decide
  // whether their contents mean anything, which keeps them mappable to SRAM.
  always_ff @(posedge clk) begin
    if (wr_en)     data_ram[{wr_index, wr_word}] <= wr_data;
    if (set_valid) tag_ram[wr_index]             <= set_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         valid_q           <= '0;
    else if (flush)     valid_q           <= '0;
    else if (set_valid) valid_q[wr_index] <= 1'b1;
  end

  assign rd_data  = data_ram[{rd_index, rd_word}];
  assign rd_tag   = tag_ram[rd_index];
  assign rd_valid = valid_q[rd_index];
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, line refill one
// word per memory transaction, tolerant of data-side stalls.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32,
  parameter int LINE_WORDS = 4,
  parameter int INDEX_SIZE = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  flush,
  output logic [LEN-1:0]        inst,
  output logic                  inst_valid,
  output logic                  busy,
  instruction_cache_if.master   mem
);
  localparam int WSEL_W  = $clog2(LINE_WORDS);
  localparam int OFFSET  = WSEL_W + 2;
  localparam int TAG_W   = ADDR_WIDTH - OFFSET - INDEX_SIZE;
  localparam int WADDR_W = ADDR_WIDTH - 2;

  icache_state_e         state_q, state_d;
  logic [WSEL_W-1:0]     cnt_q, cnt_d;
  logic [WADDR_W-1:0]    req_q, req_d;
  logic [LEN-1:0]        inst_d;
  logic                  inst_valid_d;
  logic                  flushed_q, flushed_d;

  logic [WADDR_W-1:0]    look;
  logic [WSEL_W-1:0]     look_word;
  logic [INDEX_SIZE-1:0] look_index;
  logic [TAG_W-1:0]      look_tag;
  logic [LEN-1:0]        rd_data, swapped;
  logic [TAG_W-1:0]      rd_tag;
  logic                  rd_valid, hit, last_word, wr_en, set_valid;
  logic [1:0]            mem_cmd;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [1:0]            unused_pc_lsbs;

  assign unused_pc_lsbs = pc[1:0];

  // Lookups use the live pc in IDLE and the latched request during a refill.
  assign look       = (state_q == ICACHE_IDLE) ? pc[ADDR_WIDTH-1:2] : req_q;
  assign look_word  = look[WSEL_W-1:0];
  assign look_index = look[WSEL_W +: INDEX_SIZE];
  assign look_tag   = look[WADDR_W-1 -: TAG_W];
  assign hit        = rd_valid && (rd_tag == look_tag);
  assign swapped    = byte_swap(mem.mem_data);
  assign last_word  = (cnt_q == WSEL_W'(LINE_WORDS - 1));

  icache_data_array #(
    .LEN(LEN), .INDEX_SIZE(INDEX_SIZE), .WSEL_W(WSEL_W), .TAG_W(TAG_W)
  ) u_array (
    .clk(clk), .rst_n(rst_n),
    .rd_index(look_index), .rd_word(look_word),
    .rd_data(rd_data), .rd_tag(rd_tag), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_index(look_index), .wr_word(cnt_q), .wr_data(swapped),
    .set_valid(set_valid), .set_tag(look_tag), .flush(flush)
  );

  // NOTE: every signal gets a default before the case so that no path
  // leaves one unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_d        = req_q;
    inst_d       = inst;
    inst_valid_d = 1'b0;
    flushed_d    = flushed_q | flush;
    mem_cmd      = MEM_NOP;
    mem_addr     = '0;
    wr_en        = 1'b0;
    set_valid    = 1'b0;
    unique case (state_q)
      ICACHE_IDLE: begin
        flushed_d = 1'b0;
        if (fetch_req && !flush) begin
          if (hit) begin
            inst_d       = rd_data;
            inst_valid_d = 1'b1;
          end else begin
            req_d   = pc[ADDR_WIDTH-1:2];
            cnt_d   = '0;
            state_d = ICACHE_FILL_REQ;
          end
        end
      end
      ICACHE_FILL_REQ: begin
        mem_cmd  = MEM_READ;
        mem_addr = {req_q[WADDR_W-1:WSEL_W], cnt_q, 2'b00};
        state_d  = ICACHE_FILL_WAIT;
      end
      ICACHE_FILL_WAIT: begin
        mem_cmd  = MEM_READ;
        mem_addr = {req_q[WADDR_W-1:WSEL_W], cnt_q, 2'b00};
        if (mem.mem_status == MEM_INST_FINISHED) begin
          wr_en = 1'b1;
          if (last_word) begin
            // A flush seen at any point of the refill leaves the line invalid.
            set_valid    = !(flushed_q || flush);
            inst_d       = (look_word == cnt_q) ? swapped : rd_data;
            inst_valid_d = 1'b1;
            cnt_d        = '0;
            state_d      = ICACHE_IDLE;
          end else begin
            cnt_d   = cnt_q + WSEL_W'(1);
            state_d = ICACHE_FILL_REQ;
          end
        end
      end
      default: state_d = ICACHE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ICACHE_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      req_q      <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      flushed_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      inst       <= inst_d;
      inst_valid <= inst_valid_d;
      flushed_q  <= flushed_d;
    end
  end

  assign busy                       = (state_q != ICACHE_IDLE);
  assign mem.i_cache_mem_vis_signal = mem_cmd;
  assign mem.i_cache_mem_vis_addr   = mem_addr;
endmodule

// File: tb/tb_instruction_cache.sv
// Self-checking bench: a cycle timeline of stimulus and expected outputs is
// built from a line-level cache model, then replayed against the DUT.
module tb_instruction_cache;
  import instruction_cache_pkg::*;

  localparam int AW   = 17;
  localparam int LEN  = 32;
  localparam int MAXC = 16384;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           fetch_req = 1'b0;
  logic           flush = 1'b0;
  logic [AW-1:0]  pc = '0;
  logic [LEN-1:0] inst;
  logic           inst_valid, busy;

  instruction_cache_if #(.ADDR_WIDTH(AW), .LEN(LEN)) mem_if ();

  instruction_cache #(
    .ADDR_WIDTH(AW), .LEN(LEN), .LINE_WORDS(4), .INDEX_SIZE(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc(pc), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .busy(busy), .mem(mem_if)
  );

  always #5 clk = ~clk;

  logic [7:0] mem_b [0:(1<<AW)-1];

  bit          in_req [MAXC];
  int          in_pc [MAXC];
  bit          in_flush [MAXC];
  bit          in_rst [MAXC];
  logic [1:0]  in_status [MAXC];
  logic [31:0] in_data [MAXC];
  bit          exp_read [MAXC];
  int          exp_addr [MAXC];
  bit          exp_busy [MAXC];
  bit          exp_valid [MAXC];
  logic [31:0] exp_inst [MAXC];
  bit          lit_on [MAXC];
  logic [31:0] lit_inst [MAXC];

  bit m_valid [64];
  int m_tag [64];
  int t;
  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] bus_word(input int a);
    return {mem_b[a], mem_b[a+1], mem_b[a+2], mem_b[a+3]};
  endfunction

  function automatic logic [31:0] inst_word(input int a);
    return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic gen_idle(input int n, input int flush_pct);
    for (int i = 0; i < n; i++) begin
      if (int'($urandom_range(0, 99)) < flush_pct) begin
        in_flush[t] = 1'b1;
        clear_model();
      end
      t++;
    end
  endtask

  // One fetch: flush_off 0 = flush with the request, >0 = flush that many
  // cycles after it; rst_off >0 = reset that many cycles after the request.
  task automatic gen_fetch(input int a, input int st [4], input int flush_off, input int rst_off);
    int idx, tg, base, c;
    bit flushed;
    idx = (a / 16) % 64;
    tg = a / 1024;
    base = a - (a % 16);
    flushed = 1'b0;
    in_req[t] = 1'b1;
    in_pc[t] = a;
    if (flush_off == 0) begin
      in_flush[t] = 1'b1;
      clear_model();
      t++;
      return;
    end
    if (m_valid[idx] && m_tag[idx] == tg) begin
      exp_valid[t+1] = 1'b1;
      exp_inst[t+1] = inst_word(a);
      t++;
      return;
    end
    c = t + 1;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < st[k] + 2; j++) begin
        in_req[c] = 1'b1;
        in_pc[c] = a;
        exp_read[c] = 1'b1;
        exp_addr[c] = base + 4 * k;
        exp_busy[c] = 1'b1;
        if (j == st[k] + 1) begin
          in_status[c] = MEM_INST_FINISHED;
          in_data[c] = bus_word(base + 4 * k);
        end else if (j > 0) begin
          in_status[c] = ($urandom_range(0, 1) == 0) ? MEM_RESTING : MEM_DATA_FINISHED;
        end
        if (c - t == flush_off) begin
          in_flush[c] = 1'b1;
          flushed = 1'b1;
          clear_model();
        end
        if (c - t == rst_off) begin
          in_rst[c] = 1'b1;
          in_req[c] = 1'b0;
          clear_model();
          t = c + 1;
          return;
        end
        c++;
      end
    end
    exp_valid[c] = 1'b1;
    exp_inst[c] = inst_word(a);
    if (!flushed) begin
      m_valid[idx] = 1'b1;
      m_tag[idx] = tg;
    end
    t = c;
  endtask

  task automatic lit(input int c, input logic [31:0] v);
    lit_on[c] = 1'b1;
    lit_inst[c] = v;
  endtask

  function automatic int pick_addr();
    int idx, tg;
    case ($urandom_range(0, 4))
      0: idx = 0;
      1: idx = 1;
      2: idx = 2;
      3: idx = 3;
      default: idx = 63;
    endcase
    case ($urandom_range(0, 3))
      0: tg = 0;
      1: tg = 1;
      2: tg = 2;
      default: tg = 127;
    endcase
    return tg * 1024 + idx * 16 + 4 * int'($urandom_range(0, 3));
  endfunction

  task automatic step(input int c);
    rst_n = 1'b1;
    check("mem_signal", 32'(mem_if.i_cache_mem_vis_signal),
          exp_read[c] ? 32'(MEM_READ) : 32'(MEM_NOP));
    if (exp_read[c]) check("mem_addr", 32'(mem_if.i_cache_mem_vis_addr), 32'(exp_addr[c]));
    check("busy", 32'(busy), 32'(exp_busy[c]));
    check("inst_valid", 32'(inst_valid), 32'(exp_valid[c]));
    if (exp_valid[c]) check("inst", inst, exp_inst[c]);
    if (lit_on[c]) begin
      check("lit_valid", 32'(inst_valid), 32'd1);
      check("lit_inst", inst, lit_inst[c]);
    end
    fetch_req = in_req[c];
    pc = AW'(in_pc[c]);
    flush = in_flush[c];
    mem_if.mem_status = in_status[c];
    mem_if.mem_data = in_data[c];
    if (in_rst[c]) begin
      rst_n = 1'b0;
      #1;
      check("rst_signal", 32'(mem_if.i_cache_mem_vis_signal), 32'(MEM_NOP));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst", inst, 32'd0);
    end
  endtask

  initial begin
    int t0;
    mem_if.mem_status = MEM_RESTING;
    mem_if.mem_data = '0;
    for (int i = 0; i < (1 << AW); i++) mem_b[i] = 8'($urandom);
    for (int i = 0; i < MAXC; i++) begin
      in_status[i] = 2'($urandom_range(0, 2));
      in_data[i] = $urandom;
    end
    mem_b[0] = 8'h13; mem_b[1] = 8'h05; mem_b[2] = 8'h00; mem_b[3] = 8'h00;
    mem_b[4] = 8'h93; mem_b[5] = 8'h05; mem_b[6] = 8'h10; mem_b[7] = 8'h00;
    mem_b[8] = 8'h13; mem_b[9] = 8'h06; mem_b[10] = 8'h20; mem_b[11] = 8'h00;
    mem_b[12] = 8'h67; mem_b[13] = 8'h80; mem_b[14] = 8'h00; mem_b[15] = 8'h00;
    mem_b[32'h408] = 8'h13; mem_b[32'h409] = 8'h07; mem_b[32'h40a] = 8'h30; mem_b[32'h40b] = 8'h00;
    mem_b[32'h20] = 8'hb3; mem_b[32'h21] = 8'h00; mem_b[32'h22] = 8'h00; mem_b[32'h23] = 8'h00;
    mem_b[32'h30] = 8'h6f; mem_b[32'h31] = 8'h00; mem_b[32'h32] = 8'h00; mem_b[32'h33] = 8'h00;
    clear_model();
    t = 0;

    gen_idle(2, 0);
    t0 = t; gen_fetch(32'h0, '{0, 0, 0, 0}, -1, -1); lit(t0 + 9, 32'h00000513);
    t0 = t; gen_fetch(32'h4, '{0, 0, 0, 0}, -1, -1); gen_fetch(32'h8, '{0, 0, 0, 0}, -1, -1);
    lit(t0 + 1, 32'h00100593); lit(t0 + 2, 32'h00200613);
    gen_idle(1, 0);
    gen_fetch(32'h400, '{0, 0, 0, 0}, -1, -1);
    t0 = t; gen_fetch(32'h0, '{0, 0, 0, 0}, -1, -1); lit(t0 + 9, 32'h00000513);
    t0 = t; gen_fetch(32'h408, '{0, 0, 3, 0}, -1, -1); lit(t0 + 12, 32'h00300713);
    gen_fetch(32'h408, '{0, 0, 0, 0}, 0, -1);
    t0 = t; gen_fetch(32'h408, '{0, 0, 0, 0}, -1, -1); lit(t0 + 9, 32'h00300713);
    t0 = t; gen_fetch(32'h20, '{0, 0, 0, 0}, 5, -1); lit(t0 + 9, 32'h000000b3);
    t0 = t; gen_fetch(32'h20, '{0, 0, 0, 0}, -1, -1); lit(t0 + 9, 32'h000000b3);
    gen_fetch(32'h30, '{0, 0, 0, 0}, -1, 4);
    gen_idle(1, 0);
    t0 = t; gen_fetch(32'h30, '{0, 0, 0, 0}, -1, -1); lit(t0 + 9, 32'h0000006f);
    gen_idle(2, 0);

    for (int n = 0; n < 260 && t < MAXC - 60; n++) begin
      int a, fo, ro, r;
      int st [4];
      a = pick_addr();
      for (int k = 0; k < 4; k++)
        st[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fo = -1;
      ro = -1;
      r = int'($urandom_range(0, 99));
      if (r < 5) fo = 0;
      else if (r < 10) fo = int'($urandom_range(1, 8));
      else if (r < 13) ro = int'($urandom_range(1, 8));
      gen_fetch(a, st, fo, ro);
      gen_idle(int'($urandom_range(0, 2)), 10);
    end
    gen_idle(2, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_signal", 32'(mem_if.i_cache_mem_vis_signal), 32'(MEM_NOP));
    check("reset_addr", 32'(mem_if.i_cache_mem_vis_addr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(inst_valid), 32'd0);
    check("reset_inst", inst, 32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < t; c++) begin
      @(negedge clk);
      step(c);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped, read-only instruction cache between the fetch stage and main memory; serves one 32-bit instruction per fetch request.
- On a miss, refills a whole line from main memory through the 4-byte i-cache port, one word per memory transaction.
- Main memory returns bytes in memory order (addr+0 in bits [31:24]). This block byte-swaps each word into little-endian instruction form.
- Data-side memory accesses have priority; this block tolerates arbitrary stalls from them.

Parameters:
- ADDR_WIDTH, 17, byte-address width of main memory.
- LEN, 32, data/instruction width.
- LINE_WORDS, 4, 32-bit words per cache line (power of 2).
- INDEX_SIZE, 6, log2 of the number of lines (64 lines, 1 KiB).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- fetch_req  input  1  fetch request; sampled only in IDLE.
- pc  input  ADDR_WIDTH  fetch byte address; bits [1:0] must be 0.
- flush  input  1  invalidate all lines (fence.i).
- inst  output  LEN  fetched instruction, little-endian form.
- inst_valid  output  1  one-cycle pulse qualifying inst.
- busy  output  1  high whenever state != IDLE.
- mem_status  input  2  main-memory status: MEM_RESTING / MEM_DATA_FINISHED / MEM_INST_FINISHED.
- mem_data  input  LEN  main-memory read data, memory byte order.
- i_cache_mem_vis_signal  output  2  MEM_NOP or MEM_READ.
- i_cache_mem_vis_addr  output  ADDR_WIDTH  word-aligned refill address.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all valid bits=0, word counter=0.
  - inst=0, inst_valid=0, busy=0, i_cache_mem_vis_signal=MEM_NOP, i_cache_mem_vis_addr=0.
  - Reset during a refill abandons it; no inst_valid is produced.
- Address split:
  - OFFSET = log2(LINE_WORDS)+2.
  - index = pc[OFFSET+INDEX_SIZE-1:OFFSET].
  - tag = pc[ADDR_WIDTH-1:OFFSET+INDEX_SIZE].
  - word select = pc[OFFSET-1:2].
- IDLE:
  - Drives MEM_NOP.
  - fetch_req=1 and hit (valid and tag match): at the sampling edge, inst <= word and inst_valid <= 1. Hit latency is 1 cycle; back-to-back hits give one instruction per cycle.
  - fetch_req=1 and miss: latch pc, line_base = {pc[ADDR_WIDTH-1:OFFSET], 0}, counter=0, go to FILL_REQ.
  - inst_valid is 0 in every cycle that does not follow a hit or a refill completion.
- FILL_REQ:
  - Drives MEM_READ with addr = line_base + 4*counter.
  - mem_status is ignored here, because it reflects the previous transaction.
  - Unconditionally goes to FILL_WAIT.
- FILL_WAIT:
  - Keeps driving MEM_READ at the same address.
  - mem_status=MEM_INST_FINISHED: store {mem_data[7:0], mem_data[15:8], mem_data[23:16], mem_data[31:24]} into data[index][counter].
    - If counter==LINE_WORDS-1: set valid, write tag, inst <= requested word (the word just received when word select == counter), inst_valid <= 1, go to IDLE.
    - Otherwise counter+1 and go to FILL_REQ.
  - Any other mem_status (data-side priority): stay in FILL_WAIT holding the request.
- Uncontended miss latency: request sampled at edge 0, word k accepted at edge 2k+2, inst_valid high in the cycle after edge 2*LINE_WORDS (edge 8 by default).
- fetch_req while busy is ignored. The requester holds fetch_req/pc until inst_valid.
- flush:
  - Clears all valid bits at the edge.
  - In IDLE, flush beats a simultaneous fetch_req: the request is dropped with no inst_valid, and the requester re-issues.
  - During a refill, the refill completes and the instruction is delivered, but the refilled line is NOT marked valid.
- The counter wraps only via the LINE_WORDS-1 check and never exceeds LINE_WORDS-1.

Decomposition:
- Shared defines (existing defines file):
  - MEM_NOP/MEM_READ/MEM_WRITE.
  - MEM_RESTING/MEM_DATA_FINISHED/MEM_INST_FINISHED.
  - New ICACHE_IDLE/ICACHE_FILL_REQ/ICACHE_FILL_WAIT state encodings.
- One sub-module: icache_data_array.
  - Holds the tag and valid arrays plus the word-addressed data RAM.
  - Synchronous write, combinational read.
  - The FSM stays in instruction_cache.

Test Plan:
- Cold miss: memory bytes 0x0000..0x000F = 13 05 00 00 …, fetch_req pc=0x0000 -> four MEM_READ at 0x0000/0x0004/0x0008/0x000C; inst=0x00000513 with inst_valid in the cycle after edge 8.
- Hit: after the cold miss, pc=0x0004 then pc=0x0008 on consecutive cycles -> inst_valid on two consecutive cycles, one cycle after each request, with no memory traffic.
- Conflict: pc=0x0400 (same index 0, new tag) -> refill from 0x0400; a following pc=0x0000 misses again.
- Contention: mem_status=MEM_DATA_FINISHED for 3 cycles during word 2 -> FILL_WAIT holds addr 0x0008; completion is delayed by exactly 3 cycles and data is correct.
- Flush: flush in IDLE with fetch_req pc=0x0000 -> no inst_valid, and the re-issued fetch misses. Flush mid-refill -> instruction delivered, and the same pc misses afterwards.
- Reset mid-refill: rst_n low in FILL_WAIT -> immediate MEM_NOP, busy=0, no inst_valid; the next fetch misses.
